// File: rtl/resp_packet_tx_pkg.sv
// Shared definitions for the response-packet transmitter: opcodes, header
// geometry, FSM state encoding and the length-field helper.
// Optional build macro: RESP_CHECKSUM_EN adds a trailing XOR checksum frame.
package resp_packet_tx_pkg;

    // Opcodes shared with the command-packet parser.
    localparam logic [7:0] OP_ECHO = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_DIV  = 8'h04;

    // Frames ahead of the payload: opcode, reserved, length LSB, length MSB.
    localparam int HDR_FRAMES = 4;

`ifdef RESP_CHECKSUM_EN
    localparam int TRAILER_FRAMES = 1;
`else
    localparam int TRAILER_FRAMES = 0;
`endif

    // Encoding is visible on state_o, so the values are fixed.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_HDR_OP  = 5'b00010,
        ST_HDR_RSV = 5'b00011,
        ST_HDR_LSB = 5'b00100,
        ST_HDR_MSB = 5'b00101,
        ST_PAYLOAD = 5'b00110,
        ST_CSUM    = 5'b00111
    } tx_state_t;

    // Length field counts every frame of the packet, header included.
    function automatic logic [15:0] frame_len(input logic [3:0] nbytes);
        return 16'(HDR_FRAMES + TRAILER_FRAMES) + {12'd0, nbytes};
    endfunction

endpackage

// File: rtl/resp_packet_tx_shift_8.sv
// Byte-lane shift register for payload serialisation: loads a full word,
// shifts right by one byte on request, and exposes the low byte.
module tx_shift_8 #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              shift_i,
    output logic [7:0]        data_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;

    // Each lane takes the new word on load, its upper neighbour on shift
    // (zero for the top lane), otherwise holds.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            if (gi == NB - 1) begin : g_top
                assign word_d[gi*8 +: 8] = load_i  ? data_i[gi*8 +: 8] :
                                           shift_i ? 8'h00 :
                                                     word_q[gi*8 +: 8];
            end else begin : g_mid
                assign word_d[gi*8 +: 8] = load_i  ? data_i[gi*8 +: 8] :
                                           shift_i ? word_q[(gi+1)*8 +: 8] :
                                                     word_q[gi*8 +: 8];
            end
        end
    endgenerate

    // Word register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign data_o = word_q[7:0];

endmodule

// File: rtl/resp_packet_tx.sv
// Response framer: serialises opcode + result word into a byte stream
// (opcode, reserved, LEN lsb, LEN msb, payload LSB-first) on valid/ready.
// Optional build macro: RESP_CHECKSUM_EN appends an XOR-of-all-frames byte.
module resp_packet_tx
    import resp_packet_tx_pkg::*;
#(
    parameter int         DATA_W    = 64,
    parameter int         MAX_BYTES = DATA_W / 8,
    parameter logic [7:0] RSVD_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid_i,
    output logic              start_ready_o,
    input  logic [7:0]        opcode_i,
    input  logic [3:0]        nbytes_i,
    input  logic [DATA_W-1:0] result_i,
    output logic [7:0]        data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic [4:0]        state_o
);

    tx_state_t  state_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic [3:0] nbytes_q;
    logic [3:0] cnt_q;
`ifdef RESP_CHECKSUM_EN
    logic [7:0] csum_q;
`endif

    logic        accept;
    logic        hs;
    logic        last_payload;
    logic        shift_en;
    logic [3:0]  nbytes_clamped;
    logic [15:0] len_w;
    logic [7:0]  payload_byte;

    assign start_ready_o  = (state_q == ST_IDLE) && !rst;
    assign accept         = start_valid_i && start_ready_o;
    assign hs             = valid_q && ready_i;
    assign nbytes_clamped = (32'(nbytes_i) > MAX_BYTES) ? 4'(MAX_BYTES) : nbytes_i;
    assign len_w          = frame_len(nbytes_q);
    assign last_payload   = (cnt_q == nbytes_q - 4'd1);

    // Advance the payload word whenever its current low byte is moved into data_q.
    assign shift_en = hs && (((state_q == ST_HDR_MSB) && (nbytes_q != 4'd0)) ||
                             ((state_q == ST_PAYLOAD) && !last_payload));

    tx_shift_8 #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .data_i  (result_i),
        .shift_i (shift_en),
        .data_o  (payload_byte)
    );

    // Packet FSM: each state presents one registered frame and moves on after its handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            nbytes_q <= 4'd0;
            cnt_q    <= 4'd0;
`ifdef RESP_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
`ifdef RESP_CHECKSUM_EN
            if (hs) begin
                csum_q <= csum_q ^ data_q;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q  <= ST_HDR_OP;
                        data_q   <= opcode_i;
                        valid_q  <= 1'b1;
                        nbytes_q <= nbytes_clamped;
                        cnt_q    <= 4'd0;
`ifdef RESP_CHECKSUM_EN
                        csum_q   <= 8'h00;
`endif
                    end
                end
                ST_HDR_OP: begin
                    if (hs) begin
                        state_q <= ST_HDR_RSV;
                        data_q  <= RSVD_BYTE;
                    end
                end
                ST_HDR_RSV: begin
                    if (hs) begin
                        state_q <= ST_HDR_LSB;
                        data_q  <= len_w[7:0];
                    end
                end
                ST_HDR_LSB: begin
                    if (hs) begin
                        state_q <= ST_HDR_MSB;
                        data_q  <= len_w[15:8];
                    end
                end
                ST_HDR_MSB: begin
                    if (hs) begin
                        if (nbytes_q != 4'd0) begin
                            state_q <= ST_PAYLOAD;
                            data_q  <= payload_byte;
                        end else begin
`ifdef RESP_CHECKSUM_EN
                            state_q <= ST_CSUM;
                            data_q  <= csum_q ^ data_q;
`else
                            state_q <= ST_IDLE;
                            data_q  <= 8'h00;
                            valid_q <= 1'b0;
`endif
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (hs) begin
                        if (last_payload) begin
                            cnt_q <= 4'd0;
`ifdef RESP_CHECKSUM_EN
                            state_q <= ST_CSUM;
                            data_q  <= csum_q ^ data_q;
`else
                            state_q <= ST_IDLE;
                            data_q  <= 8'h00;
                            valid_q <= 1'b0;
`endif
                        end else begin
                            cnt_q  <= cnt_q + 4'd1;
                            data_q <= payload_byte;
                        end
                    end
                end
`ifdef RESP_CHECKSUM_EN
                ST_CSUM: begin
                    if (hs) begin
                        state_q <= ST_IDLE;
                        data_q  <= 8'h00;
                        valid_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    data_q  <= 8'h00;
                    valid_q <= 1'b0;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign state_o = state_q;

endmodule
